// File: rtl/led_pkg.sv
// Shared encodings for the LED pattern generator: channel modes and breathe direction.
package led_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_ON      = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // Channel 0 comes out of reset blinking as a power-on heartbeat.
  function automatic mode_e reset_mode(input int ch);
    return (ch == 0) ? MODE_BLINK : MODE_OFF;
  endfunction

endpackage

// File: rtl/led_channel.sv
// One LED channel: mode register, blink phase, breathe duty/direction and the
// registered LED drive (before any output polarity inversion).
module led_channel
  import led_pkg::*;
#(
  parameter int    PWM_WIDTH = 8,
  parameter mode_e RST_MODE  = MODE_OFF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  mode_e                wr_mode,
  input  logic                 tick,
  input  logic [PWM_WIDTH-1:0] pwm_cnt,
  output logic                 led
);

  localparam logic [PWM_WIDTH-1:0] DUTY_MAX = '1;

  mode_e                mode_q, mode_d;
  dir_e                 dir_q, dir_d;
  logic                 phase_q, phase_d;
  logic [PWM_WIDTH-1:0] duty_q, duty_d;
  logic                 led_q, led_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q  <= RST_MODE;
      dir_q   <= DIR_UP;
      phase_q <= 1'b0;
      duty_q  <= '0;
      led_q   <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      dir_q   <= dir_d;
      phase_q <= phase_d;
      duty_q  <= duty_d;
      led_q   <= led_d;
    end
  end

  always_comb begin
    mode_d  = mode_q;
    dir_d   = dir_q;
    phase_d = phase_q;
    duty_d  = duty_q;
    led_d   = 1'b0;

    unique case (mode_q)
      MODE_OFF:     led_d = 1'b0;
      MODE_ON:      led_d = 1'b1;
      MODE_BLINK:   led_d = phase_q;
      MODE_BREATHE: led_d = (pwm_cnt < duty_q);
      default:      led_d = 1'b0;
    endcase

    // A write restarts the pattern and suppresses a coincident tick.
    if (wr_en) begin
      mode_d  = wr_mode;
      phase_d = 1'b0;
      duty_d  = '0;
      dir_d   = DIR_UP;
    end else if (tick) begin
      if (mode_q == MODE_BLINK) begin
        phase_d = ~phase_q;
      end else if (mode_q == MODE_BREATHE) begin
        // Duty bounces off both ends instead of wrapping.
        unique case (dir_q)
          DIR_UP: begin
            if (duty_q != DUTY_MAX) begin
              duty_d = duty_q + 1'b1;
            end else begin
              dir_d  = DIR_DOWN;
              duty_d = duty_q - 1'b1;
            end
          end
          DIR_DOWN: begin
            if (duty_q != '0) begin
              duty_d = duty_q - 1'b1;
            end else begin
              dir_d  = DIR_UP;
              duty_d = duty_q + 1'b1;
            end
          end
          default: dir_d = DIR_UP;
        endcase
      end
    end
  end

  assign led = led_q;

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: shared prescaler tick and PWM counter,
// config write decode, and one led_channel per LED.
module led_pattern_gen
  import led_pkg::*;
#(
  parameter int N_LEDS     = 4,
  parameter int PRESCALE   = 2**25,
  parameter int PWM_WIDTH  = 8,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [3:0]        cfg_ch,
  input  logic [1:0]        cfg_mode,
  output logic [N_LEDS-1:0] user_led,
  output logic              tick
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0]      prescale_q, prescale_d;
  logic [PWM_WIDTH-1:0] pwm_q, pwm_d;
  logic                 ready_q, ready_d;
  logic [N_LEDS-1:0]    wr_en;
  logic [N_LEDS-1:0]    led_raw;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      prescale_q <= '0;
      pwm_q      <= '0;
      ready_q    <= 1'b0;
    end else begin
      prescale_q <= prescale_d;
      pwm_q      <= pwm_d;
      ready_q    <= ready_d;
    end
  end

  always_comb begin
    prescale_d = (prescale_q == PS_LAST) ? '0 : prescale_q + 1'b1;
    pwm_d      = pwm_q + 1'b1;
    ready_d    = 1'b1;
  end

  assign tick      = (prescale_q == PS_LAST);
  assign cfg_ready = ready_q;

  // Valid/ready: a write transfers in any cycle where cfg_valid and cfg_ready
  // are both high; writes to channels beyond N_LEDS are accepted and dropped.
  always_comb begin
    wr_en = '0;
    for (int i = 0; i < N_LEDS; i++) begin
      wr_en[i] = cfg_valid && ready_q && (cfg_ch == 4'(i));
    end
  end

  for (genvar gi = 0; gi < N_LEDS; gi++) begin : g_ch
    led_channel #(
      .PWM_WIDTH (PWM_WIDTH),
      .RST_MODE  (reset_mode(gi))
    ) u_ch (
      .clk     (sys_clk),
      .rst     (sys_rst),
      .wr_en   (wr_en[gi]),
      .wr_mode (mode_e'(cfg_mode)),
      .tick    (tick),
      .pwm_cnt (pwm_q),
      .led     (led_raw[gi])
    );
  end

  assign user_led = led_raw ^ {N_LEDS{ACTIVE_LOW}};

endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench for led_pattern_gen: randomized writes, a tick-count reference model,
// and a scoreboard drained by a monitor once per clock.
module tb_led_pattern_gen;

  localparam int N  = 4;
  localparam int PS = 4;
  localparam int PW = 3;
  localparam int PERIOD_PWM = 8;
  localparam logic [1:0] M_OFF = 2'd0, M_ON = 2'd1, M_BLINK = 2'd2, M_BREATHE = 2'd3;

  // ---------------- clock / reset ----------------
  logic         sys_clk   = 1'b0;
  logic         sys_rst   = 1'b1;
  logic         cfg_valid = 1'b0;
  logic [3:0]   cfg_ch    = '0;
  logic [1:0]   cfg_mode  = '0;
  logic         cfg_ready, cfg_ready_lo;
  logic [N-1:0] user_led, user_led_lo;
  logic         tick, tick_lo;

  always #5 sys_clk = ~sys_clk;

  led_pattern_gen #(.N_LEDS(N), .PRESCALE(PS), .PWM_WIDTH(PW), .ACTIVE_LOW(1'b0)) u_dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_mode(cfg_mode), .user_led(user_led), .tick(tick)
  );

  led_pattern_gen #(.N_LEDS(N), .PRESCALE(PS), .PWM_WIDTH(PW), .ACTIVE_LOW(1'b1)) u_dut_lo (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready_lo),
    .cfg_ch(cfg_ch), .cfg_mode(cfg_mode), .user_led(user_led_lo), .tick(tick_lo)
  );

  // ---------------- scoreboard state ----------------
  int errors = 0;
  int checks = 0;
  logic [4:0] exp_q[$];   // {tick, user_led} expected after the next rising edge

  // ---------------- reference model ----------------
  // Each channel is described by its mode and the number of ticks it has
  // spent in that mode since its last write.
  int cyc;
  int m_mode[N];
  int m_ts[N];

  function automatic int tri_duty(input int ts);
    int t;
    t = ts % 14;
    return (t <= 7) ? t : 14 - t;
  endfunction

  function automatic logic led_of(input int ch, input int pwm);
    case (m_mode[ch])
      1:       return 1'b1;
      2:       return (m_ts[ch] % 2) == 1;
      3:       return pwm < tri_duty(m_ts[ch]);
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    cyc = 0;
    for (int i = 0; i < N; i++) begin
      m_mode[i] = (i == 0) ? 2 : 0;
      m_ts[i]   = 0;
    end
  endtask

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called positioned at a falling edge; drives one cycle and returns at the next.
  task automatic step(input logic v, input logic [3:0] ch, input logic [1:0] md);
    logic [N-1:0] e_led;
    logic         e_tick;
    logic         acc;
    logic         tick_now;
    cfg_valid = v;
    cfg_ch    = ch;
    cfg_mode  = md;
    e_tick = ((cyc + 1) % PS) == (PS - 1);
    for (int i = 0; i < N; i++) e_led[i] = led_of(i, cyc % PERIOD_PWM);
    exp_q.push_back({e_tick, e_led});
    acc      = v && (cyc >= 1);
    tick_now = (cyc % PS) == (PS - 1);
    for (int i = 0; i < N; i++) begin
      if (acc && (int'(ch) == i)) begin
        m_mode[i] = int'(md);
        m_ts[i]   = 0;
      end else if (tick_now && (m_mode[i] >= 2)) begin
        m_ts[i]++;
      end
    end
    cyc++;
    @(negedge sys_clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      step(1'b0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
    end
  endtask

  task automatic write_in_tick(input logic [3:0] ch, input logic [1:0] md);
    while ((cyc % PS) != (PS - 1)) idle(1);
    step(1'b1, ch, md);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_led"},     user_led,           4'h0);
    check({tag, "_led_lo"},  user_led_lo,        4'hF);
    check({tag, "_ready"},   {3'b0, cfg_ready},  4'h0);
    check({tag, "_tick"},    {3'b0, tick},       4'h0);
    check({tag, "_ready_lo"}, {3'b0, cfg_ready_lo}, 4'h0);
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [4:0] e;
    forever begin
      @(posedge sys_clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("tick",     {3'b0, tick},         {3'b0, e[4]});
        check("tick_lo",  {3'b0, tick_lo},      {3'b0, e[4]});
        check("ready",    {3'b0, cfg_ready},    4'h1);
        check("ready_lo", {3'b0, cfg_ready_lo}, 4'h1);
        check("led",      user_led,             e[3:0]);
        check("led_lo",   user_led_lo,          ~e[3:0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    repeat (3) @(negedge sys_clk);
    check_reset_outputs("por");
    sys_rst = 1'b0;
    model_reset();

    idle(40);                                  // heartbeat only
    step(1'b1, 4'd2, M_ON);      idle(6);
    step(1'b1, 4'd2, M_OFF);     idle(6);
    step(1'b1, 4'd1, M_BREATHE); idle(140);    // more than two full triangles
    write_in_tick(4'd0, M_BLINK); idle(12);
    step(1'b1, 4'd9, M_ON);      idle(8);

    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 7) == 0)
        step(1'b1, 4'($urandom_range(0, 9)), 2'($urandom_range(0, 3)));
      else
        idle(1);
    end

    step(1'b1, 4'd1, M_BREATHE);
    step(1'b1, 4'd3, M_BREATHE);
    idle(30);

    // Asynchronous reset in the middle of a clock high phase.
    @(posedge sys_clk);
    #3;
    sys_rst = 1'b1;
    #1;
    check_reset_outputs("async");
    check("q_drain_rst", 4'(exp_q.size()), 4'h0);
    repeat (3) @(negedge sys_clk);
    check_reset_outputs("hold");
    sys_rst = 1'b0;
    model_reset();
    idle(30);

    repeat (2) @(posedge sys_clk);
    #2;
    check("q_drain_end", 4'(exp_q.size()), 4'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
